// File: rtl/cipher_feeder.sv
// cipher_feeder: buffers upstream bytes in a small FIFO and presents them to a
// byte-serial cipher in 8-cycle windows, handling seeding and the reset command.
module cipher_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 seed,
  input  logic                       start,
  input  logic                       stop,
  output logic [7:0]                 ctl_out,
  output logic [7:0]                 data_out,
  output logic                       out_strobe,
  output logic                       err_seed,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    STOP,
    DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  phase, phase_nx;
  logic        stop_pend, stop_pend_nx;
  logic        win_valid, win_valid_nx;
  logic [7:0]  ctl_nx, data_nx;
  logic        strobe_nx, err_nx;
  logic        load, pop, push;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign fifo_level = wr_ptr - rd_ptr;
  assign in_ready   = (fifo_level != FULL);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE);

  // Next-state, window load and registered-output decode.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    stop_pend_nx = stop_pend;
    win_valid_nx = win_valid;
    data_nx      = data_out;
    strobe_nx    = 1'b0;
    err_nx       = 1'b0;
    load         = 1'b0;
    pop          = 1'b0;
    ctl_nx       = 8'h00;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (seed != 8'h00 && seed != 8'hFF) state_nx = SEED;
          else                                err_nx   = 1'b1;
        end
      end
      SEED: begin
        state_nx     = RUN;
        phase_nx     = '0;
        stop_pend_nx = 1'b0;
        load         = 1'b1;
      end
      RUN: begin
        if (phase == 3'd7) begin
          // The cipher samples here; report the window that just ended.
          strobe_nx = win_valid;
          if (stop_pend || stop) begin
            state_nx     = STOP;
            stop_pend_nx = 1'b0;
          end else begin
            phase_nx = '0;
            load     = 1'b1;
          end
        end else begin
          phase_nx = phase + 3'd1;
          if (stop) stop_pend_nx = 1'b1;
        end
      end
      STOP:    state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (load) begin
      pop          = (fifo_level != '0);
      win_valid_nx = pop;
      data_nx      = pop ? mem[rd_ptr[AW-1:0]] : 8'h00;
    end

    unique case (state_nx)
      SEED:    ctl_nx = seed;
      STOP:    ctl_nx = 8'hFF;
      default: ctl_nx = 8'h00;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      stop_pend  <= 1'b0;
      win_valid  <= 1'b0;
      ctl_out    <= '0;
      data_out   <= '0;
      out_strobe <= 1'b0;
      err_seed   <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      stop_pend  <= stop_pend_nx;
      win_valid  <= win_valid_nx;
      ctl_out    <= ctl_nx;
      data_out   <= data_nx;
      out_strobe <= strobe_nx;
      err_seed   <= err_nx;
    end
  end

  // FIFO pointers; one extra bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_cipher_feeder.sv
// Self-checking bench for cipher_feeder: constant tables, directed sequences
// and randomized traffic compared against a queue-based reference model.
module tb_cipher_feeder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] seed = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] ctl_out, data_out;
  logic       out_strobe, err_seed, busy;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  cipher_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .seed(seed), .start(start), .stop(stop),
    .ctl_out(ctl_out), .data_out(data_out), .out_strobe(out_strobe),
    .err_seed(err_seed), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 seed, 2 run, 3 stop, 4 drain.
  logic [7:0] mq[$];
  int         m_mode = 0;
  int         m_phase = 0;
  bit         m_pend = 0, m_wv = 0, m_strobe = 0, m_err = 0, m_acc = 0, m_load = 0;
  logic [7:0] m_ctl = '0, m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_mode = 0; m_phase = 0; m_pend = 0; m_wv = 0;
      m_strobe = 0; m_err = 0; m_ctl = '0; m_data = '0;
    end else begin
      m_acc    = in_valid && (mq.size() < DEPTH);
      m_strobe = 0;
      m_err    = 0;
      m_load   = 0;
      case (m_mode)
        0: begin
          m_ctl = 8'h00;
          if (start) begin
            if (seed != 8'h00 && seed != 8'hFF) begin m_mode = 1; m_ctl = seed; end
            else m_err = 1;
          end
        end
        1: begin m_mode = 2; m_ctl = 8'h00; m_phase = 0; m_pend = 0; m_load = 1; end
        2: begin
          if (m_phase == 7) begin
            m_strobe = m_wv;
            if (m_pend || stop) begin m_mode = 3; m_ctl = 8'hFF; m_pend = 0; end
            else begin m_phase = 0; m_load = 1; end
          end else begin
            m_phase++;
            if (stop) m_pend = 1;
          end
        end
        3: begin m_mode = 4; m_ctl = 8'h00; end
        default: begin m_mode = 0; m_ctl = 8'h00; end
      endcase
      if (m_load) begin
        if (mq.size() > 0) begin m_data = mq.pop_front(); m_wv = 1; end
        else begin m_data = 8'h00; m_wv = 0; end
      end
      if (m_acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ctl",    32'(ctl_out),    32'(m_ctl));
      chk("m_data",   32'(data_out),   32'(m_data));
      chk("m_strobe", 32'(out_strobe), 32'(m_strobe));
      chk("m_err",    32'(err_seed),   32'(m_err));
      chk("m_busy",   32'(busy),       32'(m_mode != 0));
      chk("m_level",  32'(fifo_level), 32'(mq.size()));
      chk("m_ready",  32'(in_ready),   32'(mq.size() < DEPTH));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    next();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) next();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},   32'(ctl_out),    32'h00);
    chk({tag, "_data"},  32'(data_out),   32'h00);
    chk({tag, "_strb"},  32'(out_strobe), 32'd0);
    chk({tag, "_err"},   32'(err_seed),   32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_lvl"},   32'(fifo_level), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready),   32'd1);
  endtask

  typedef struct {
    bit         st;
    logic [7:0] sd;
    bit         v;
    logic [7:0] d;
    logic [7:0] e_ctl;
    bit         e_err;
    bit         e_busy;
    int         e_lvl;
    bit         e_rdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill to capacity, then illegal seeds; each row's outputs observed next cycle.
    tbl[0] = '{0, 8'h00, 1, 8'hA0, 8'h00, 0, 0, 1, 1};
    tbl[1] = '{0, 8'h00, 1, 8'hA1, 8'h00, 0, 0, 2, 1};
    tbl[2] = '{0, 8'h00, 1, 8'hA2, 8'h00, 0, 0, 3, 1};
    tbl[3] = '{0, 8'h00, 1, 8'hA3, 8'h00, 0, 0, 4, 0};
    tbl[4] = '{0, 8'h00, 1, 8'hA4, 8'h00, 0, 0, 4, 0};
    tbl[5] = '{1, 8'h00, 0, 8'h00, 8'h00, 1, 0, 4, 0};
    tbl[6] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4, 0};
    tbl[7] = '{1, 8'hFF, 0, 8'h00, 8'h00, 1, 0, 4, 0};
    tbl[8] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4, 0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start = tbl[i].st; seed = tbl[i].sd; in_valid = tbl[i].v; in_data = tbl[i].d;
      next();
      chk($sformatf("tbl%0d_ctl", i),  32'(ctl_out),    32'(tbl[i].e_ctl));
      chk($sformatf("tbl%0d_err", i),  32'(err_seed),   32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),       32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_lvl", i),  32'(fifo_level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_rdy", i),  32'(in_ready),   32'(tbl[i].e_rdy));
    end

    // Seeded streaming of two buffered bytes.
    do_reset();
    push(8'h11);
    push(8'h22);
    chk("s1_lvl", 32'(fifo_level), 32'd2);
    start = 1'b1; seed = 8'h3C;
    next();                                   // T
    chk("s1_seed_ctl", 32'(ctl_out), 32'h3C);
    chk("s1_seed_busy", 32'(busy), 32'd1);
    next();                                   // T+1
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("s1_w0_data_%0d", i), 32'(data_out), 32'h11);
      chk($sformatf("s1_w0_strb_%0d", i), 32'(out_strobe), 32'd0);
      chk($sformatf("s1_w0_ctl_%0d", i), 32'(ctl_out), 32'h00);
      next();
    end
    chk("s1_strb9", 32'(out_strobe), 32'd1);  // T+9
    for (int i = 9; i <= 16; i++) begin
      chk($sformatf("s1_w1_data_%0d", i), 32'(data_out), 32'h22);
      if (i > 9) chk($sformatf("s1_w1_strb_%0d", i), 32'(out_strobe), 32'd0);
      next();
    end
    chk("s1_strb17", 32'(out_strobe), 32'd1); // T+17
    chk("s1_empty_data", 32'(data_out), 32'h00);
    stop = 1'b1;
    wait_idle();

    // Stop at phase 3; buffered byte survives and leads the next run.
    push(8'h77);
    push(8'h88);
    start = 1'b1; seed = 8'h42;
    next();                                   // T
    repeat (4) next();                        // T+4, phase 3
    stop = 1'b1;
    repeat (5) next();                        // T+9
    chk("s2_stop_ctl", 32'(ctl_out), 32'hFF);
    chk("s2_stop_strb", 32'(out_strobe), 32'd1);
    chk("s2_stop_busy", 32'(busy), 32'd1);
    next();
    chk("s2_drain_ctl", 32'(ctl_out), 32'h00);
    chk("s2_drain_busy", 32'(busy), 32'd1);
    next();
    chk("s2_idle_busy", 32'(busy), 32'd0);
    chk("s2_lvl", 32'(fifo_level), 32'd1);
    start = 1'b1; seed = 8'h42;
    next();
    next();
    chk("s2_retained", 32'(data_out), 32'h88);
    stop = 1'b1;
    wait_idle();

    // Empty window, then a byte arriving mid-window.
    start = 1'b1; seed = 8'h05;
    next();
    next();                                   // T+1
    chk("s3_empty", 32'(data_out), 32'h00);
    repeat (3) next();                        // T+4
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (5) next();                        // T+9
    chk("s3_nostrb", 32'(out_strobe), 32'd0);
    chk("s3_data", 32'(data_out), 32'h5A);
    repeat (8) next();                        // T+17
    chk("s3_strb", 32'(out_strobe), 32'd1);
    stop = 1'b1;
    wait_idle();

    // Reset during RUN at phase 5 with two bytes buffered.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    start = 1'b1; seed = 8'h09;
    next();
    repeat (6) next();                        // T+6, phase 5
    chk("s4_lvl", 32'(fifo_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("s4");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r;
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 3);
      seed     = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      stop     = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cipher_feeder.md
CIPHER_FEEDER -- requirements
Module: cipher_feeder

Interface
REQ-001 Parameter: DEPTH, default 4, input byte FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  8  plaintext/ciphertext byte from upstream.
REQ-005 in_valid  input  1  in_data valid; byte accepted on a clk edge with in_valid and in_ready both high.
REQ-006 in_ready  output  1  high when FIFO not full; derived from registered state only.
REQ-007 seed  input  8  cipher seed, sampled with start.
REQ-008 start  input  1  single-cycle request to seed the cipher and begin streaming.
REQ-009 stop  input  1  single-cycle request to end streaming and return the cipher to idle.
REQ-010 ctl_out  output  8  registered; drives the cipher control port (0x00 normal, seed value, 0xFF reset command).
REQ-011 data_out  output  8  registered; drives the cipher data input; stable for a full 8-cycle window.
REQ-012 out_strobe  output  1  registered one-cycle pulse; the cipher output byte for a real (non-filler) window is valid in this cycle.
REQ-013 err_seed  output  1  registered one-cycle pulse; start rejected for an illegal seed.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 fifo_level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-016 The FSM SHALL have states IDLE, SEED, RUN, STOP, DRAIN.
- IDLE: ctl_out=0x00. On start: seed not in {0x00,0xFF} -> SEED; otherwise err_seed pulses next cycle and the FSM stays in IDLE. stop is ignored.
REQ-017 SEED SHALL last exactly one cycle with ctl_out=seed, then enter RUN with phase=0 and ctl_out=0x00.
REQ-018 RUN SHALL step a 3-bit phase counter 0..7, wrapping 7->0, with phase 0 aligned to cycle 1 after SEED; start is ignored.
REQ-019 Window load: on entry to RUN and on every phase 7->0 edge, a non-empty FIFO SHALL pop its head into data_out and set win_valid=1; an empty FIFO SHALL load data_out=0x00 and set win_valid=0.
REQ-020 The cipher samples data_out at the phase-7 edge; out_strobe SHALL pulse during the following cycle iff the window just ended had win_valid=1.
REQ-021 A stop in RUN SHALL be latched and take effect at the next phase-7 edge, moving to STOP instead of loading a new window; no FIFO pop occurs at that edge.
REQ-022 STOP SHALL last one cycle with ctl_out=0xFF, then DRAIN for one cycle with ctl_out=0x00, then IDLE.
REQ-023 FIFO: first-in first-out order; push and pop in the same cycle SHALL both take effect with level unchanged; push when full is impossible (in_ready low).
REQ-024 FIFO contents SHALL be retained across stop/start.
REQ-025 out_strobe for the final window before stop SHALL still pulse, in the STOP cycle.

Reset
REQ-026 While rst_n is low: state=IDLE, phase=0, FIFO empty, fifo_level=0, ctl_out=0x00, data_out=0x00, out_strobe=0, err_seed=0, busy=0, stop latch clear, in_ready=1.
REQ-027 Reset assertion mid-RUN SHALL take effect immediately without completing the window; buffered bytes are discarded.

Verification
REQ-028 FIFO holds 0x11,0x22; start with seed 0x3C in cycle T-1 -> ctl_out=0x3C only in T; data_out=0x11 in T+1..T+8; out_strobe in T+9; data_out=0x22 in T+9..T+16; out_strobe in T+17.
REQ-029 start with seed 0x00, then with seed 0xFF -> err_seed pulses once each; ctl_out stays 0x00; busy stays 0.
REQ-030 RUN with FIFO empty -> data_out=0x00 and no out_strobe for that window; a byte 0x5A pushed at phase 3 appears on data_out at the next window start.
REQ-031 stop at phase 3 -> window completes; out_strobe and ctl_out=0xFF in the same cycle; ctl_out=0x00 the next cycle; busy low one cycle later; fifo_level unchanged.
REQ-032 DEPTH=4, no RUN, 5 consecutive pushes -> in_ready low after the 4th acceptance, fifo_level=4, 5th byte not accepted.
REQ-033 rst_n pulsed low at phase 5 with 2 bytes buffered -> all outputs at REQ-026 values immediately; fifo_level=0.
